// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sequencing controller.
// Holds the one-hot phase encodings, default phase lengths and a small
// helper used to size the phase counter.
// Optional feature macro: TRNG_SEQ_HEALTH_EN adds the HALT state (4-bit state).
package trng_pkg;

    localparam int unsigned LOAD_CYCLES_DEF = 18;
    localparam int unsigned INIT_CYCLES_DEF = 36;

`ifdef TRNG_SEQ_HEALTH_EN
    localparam int unsigned STATE_W = 4;
`else
    localparam int unsigned STATE_W = 3;
`endif

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_LOAD = STATE_W'(3'b100);
    localparam state_t ST_INIT = STATE_W'(3'b010);
    localparam state_t ST_RUN  = STATE_W'(3'b001);
`ifdef TRNG_SEQ_HEALTH_EN
    localparam state_t ST_HALT = 4'b1000;
`endif

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trng_ce_div.sv
// One NLFSR clock-enable divider channel: a DIV_W-bit modulo counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          holds the counter at 0 (asserted outside RUN)
//   div          divide ratio; 0 behaves as 1
//   tick_c       combinational tick, high when the counter sits at div-1
module trng_ce_div #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last;

    // A ratio of 0 collapses to 1, so the wrap point is 0 in both cases.
    assign last   = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick_c = (cnt_q == last);

    // Modulo counter, wraps after the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/trng_seq_ctrl.sv
// TRNG sequencing controller: steps the entropy datapath through LOAD, INIT
// and RUN, drives N_CE divided NLFSR clock-enables and handles reseed.
// Optional feature macro: TRNG_SEQ_HEALTH_EN adds health_fail/alarm and HALT.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         reseed request (acted on in RUN, and in HALT)
//   ce_div        per-channel RUN divide ratios, channel i at [i*DIV_W +: DIV_W]
//   load_en       high in LOAD
//   init_en       high in INIT
//   run_en        high in RUN
//   ce            NLFSR clock-enables
//   ready         one-cycle pulse on the first RUN cycle
//   health_fail   health-test failure strobe (macro only)
//   alarm         sticky health alarm (macro only)
module trng_seq_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF,
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned N_CE        = 3,
    parameter int unsigned DIV_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_CE*DIV_W-1:0] ce_div,
    output logic                  load_en,
    output logic                  init_en,
    output logic                  run_en,
    output logic [N_CE-1:0]       ce,
    output logic                  ready
`ifdef TRNG_SEQ_HEALTH_EN
   ,input  logic                  health_fail,
    output logic                  alarm
`endif
);

    localparam int unsigned CNT_W = $clog2(max_u(LOAD_CYCLES, INIT_CYCLES));
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [N_CE*DIV_W-1:0]   div_q;
    logic                    ready_q;
    logic [N_CE-1:0]         tick_c;
    logic                    ch_clr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
`ifdef TRNG_SEQ_HEALTH_EN
                // A health failure wins over a simultaneous reseed request.
                if (health_fail) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
`else
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
`endif
            end
`ifdef TRNG_SEQ_HEALTH_EN
            ST_HALT: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Phase enables and clock-enables decoded from the registered state.
    always_comb begin
        load_en = 1'b0;
        init_en = 1'b0;
        run_en  = 1'b0;
        ce      = '0;
        case (state_q)
            ST_LOAD: begin
                load_en = 1'b1;
                ce      = '1;
            end
            ST_INIT: begin
                init_en = 1'b1;
                ce      = {N_CE{cnt_q != '0}};
            end
            ST_RUN: begin
                run_en = 1'b1;
                ce     = tick_c;
            end
            default: ;
        endcase
    end

    // Phase counter, divide-ratio capture (LOAD only) and ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
            if (state_q == ST_LOAD) begin
                div_q <= ce_div;
            end
        end
    end

    assign ready = ready_q;

`ifdef TRNG_SEQ_HEALTH_EN
    logic alarm_q;

    // Alarm tracks residency in HALT; cleared on the start that leaves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= (state_d == ST_HALT);
        end
    end

    assign alarm = alarm_q;
`endif

    // Channel counters only advance in RUN, so each RUN entry starts at phase 0.
    assign ch_clr = (state_q != ST_RUN);

    for (genvar i = 0; i < int'(N_CE); i++) begin : g_ch
        trng_ce_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk    (clk),
            .rst    (rst),
            .clr    (ch_clr),
            .div    (div_q[i*DIV_W +: DIV_W]),
            .tick_c (tick_c[i])
        );
    end

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Self-checking bench for trng_seq_ctrl: table-driven RUN patterns, hand
// sequences for reseed/abort/health corners and a randomized run against a
// phase/cycle-index reference model.
module tb_trng_seq_ctrl;

    localparam int unsigned LC = 18;
    localparam int unsigned IC = 36;
    localparam int unsigned NC = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned TW = NC * DW;

    localparam int P_LOAD = 0;
    localparam int P_INIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_HALT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] ce_div;
    logic          load_en;
    logic          init_en;
    logic          run_en;
    logic [NC-1:0] ce;
    logic          ready;
    logic          health_fail;
    logic          alarm;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current phase, cycle index within the phase, latched ratios.
    int ph;
    int k;
    int dm [NC];

    always #5 clk = ~clk;

    trng_seq_ctrl #(
        .LOAD_CYCLES (LC),
        .INIT_CYCLES (IC),
        .N_CE        (NC),
        .DIV_W       (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ce_div      (ce_div),
        .load_en     (load_en),
        .init_en     (init_en),
        .run_en      (run_en),
        .ce          (ce),
        .ready       (ready)
`ifdef TRNG_SEQ_HEALTH_EN
       ,.health_fail (health_fail),
        .alarm       (alarm)
`endif
    );

`ifndef TRNG_SEQ_HEALTH_EN
    assign alarm = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        ph = P_LOAD;
        k  = 0;
        for (int i = 0; i < int'(NC); i++) dm[i] = 0;
    endtask

    task automatic model_step(input logic s, input logic [TW-1:0] d, input logic hf);
        case (ph)
            P_LOAD: begin
                for (int i = 0; i < int'(NC); i++) dm[i] = int'(d[i*DW +: DW]);
                if (k == int'(LC) - 1) begin ph = P_INIT; k = 0; end
                else k++;
            end
            P_INIT: begin
                if (k == int'(IC) - 1) begin ph = P_RUN; k = 0; end
                else k++;
            end
            P_RUN: begin
`ifdef TRNG_SEQ_HEALTH_EN
                if (hf) begin ph = P_HALT; k = 0; end
                else if (s) begin ph = P_LOAD; k = 0; end
                else k++;
`else
                if (s) begin ph = P_LOAD; k = 0; end
                else k++;
`endif
            end
            default: begin
                if (s) begin ph = P_LOAD; k = 0; end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [NC-1:0] e;
        for (int i = 0; i < int'(NC); i++) begin
            case (ph)
                P_LOAD:  e[i] = 1'b1;
                P_INIT:  e[i] = (k != 0);
                P_RUN:   e[i] = ((k % eff(dm[i])) == eff(dm[i]) - 1);
                default: e[i] = 1'b0;
            endcase
        end
        chk("load_en", 32'(load_en), 32'(ph == P_LOAD));
        chk("init_en", 32'(init_en), 32'(ph == P_INIT));
        chk("run_en",  32'(run_en),  32'(ph == P_RUN));
        chk("ce",      32'(ce),      32'(e));
        chk("ready",   32'(ready),   32'(ph == P_RUN && k == 0));
`ifdef TRNG_SEQ_HEALTH_EN
        chk("alarm",   32'(alarm),   32'(ph == P_HALT));
`endif
    endtask

    // Called at a falling edge: check, drive, clock, advance the model.
    task automatic step(input logic s, input logic [TW-1:0] d, input logic hf);
        compare_all();
        start       = s;
        ce_div      = d;
        health_fail = hf;
        @(posedge clk);
        model_step(s, d, hf);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_load_en"}, 32'(load_en), 32'd1);
        chk({tag, "_init_en"}, 32'(init_en), 32'd0);
        chk({tag, "_run_en"},  32'(run_en),  32'd0);
        chk({tag, "_ce"},      32'(ce),      32'((1 << NC) - 1));
        chk({tag, "_ready"},   32'(ready),   32'd0);
        chk({tag, "_alarm"},   32'(alarm),   32'd0);
    endtask

    // Asserts reset mid-cycle (away from edges), checks the immediate effect.
    task automatic do_reset(input string tag);
        #2;
        rst         = 1'b1;
        start       = 1'b0;
        health_fail = 1'b0;
        #1;
        chk_reset(tag);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [TW-1:0]         div;
        logic [NC-1:0][15:0]   mask;   // expected ce over RUN cycles 0..15 per channel
    } vec_t;

    vec_t tbl [4];

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        ce_div      = '0;
        health_fail = 1'b0;
        model_reset();

        tbl[0].div = 12'h555; tbl[0].mask = {16'h4210, 16'h4210, 16'h4210};
        tbl[1].div = 12'hF10; tbl[1].mask = {16'h4000, 16'hFFFF, 16'hFFFF};
        tbl[2].div = 12'h324; tbl[2].mask = {16'h4924, 16'hAAAA, 16'h8888};
        tbl[3].div = 12'h76F; tbl[3].mask = {16'h2040, 16'h0820, 16'h4000};

        @(negedge clk);

        // Table: ratio latched during LOAD; the inverse is driven afterwards.
        for (int v = 0; v < 4; v++) begin
            do_reset("tbl_rst");
            repeat (LC) step(1'b0, tbl[v].div, 1'b0);
            repeat (IC) step(1'b0, ~tbl[v].div, 1'b0);
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < int'(NC); i++)
                    chk("tbl_ce", 32'(ce[i]), 32'(tbl[v].mask[i][r]));
                chk("tbl_ready", 32'(ready), 32'(r == 0));
                step(1'b0, ~tbl[v].div, 1'b0);
            end
        end

        // Ratio change in RUN is ignored; reseed at RUN cycle 7 picks up ratio 3.
        do_reset("rs_rst");
        repeat (LC + IC) step(1'b0, 12'h555, 1'b0);
        repeat (7) step(1'b0, 12'h333, 1'b0);
        step(1'b1, 12'h333, 1'b0);
        chk("reseed_load_en", 32'(load_en), 32'd1);
        chk("reseed_run_en",  32'(run_en),  32'd0);
        repeat (LC) step(1'b0, 12'h333, 1'b0);
        for (int j = 0; j < int'(IC); j++) step(j >= 5 && j < 12, 12'h333, 1'b0);
        chk("init_start_ignored", 32'(run_en), 32'd1);
        for (int r = 0; r < 8; r++) begin
            chk("reseed_ce", 32'(ce), (r == 2 || r == 5) ? 32'h7 : 32'h0);
            step(1'b0, 12'h333, 1'b0);
        end

        // Reset at INIT cycle 20 aborts; a full LOAD follows.
        do_reset("ab_rst");
        repeat (LC + 20) step(1'b0, 12'h555, 1'b0);
        chk("pre_abort_init", 32'(init_en), 32'd1);
        do_reset("abort");
        for (int j = 0; j < int'(LC); j++) begin
            chk("post_abort_load", 32'(load_en), 32'd1);
            step(1'b0, 12'h555, 1'b0);
        end
        chk("post_abort_init", 32'(init_en), 32'd1);

`ifdef TRNG_SEQ_HEALTH_EN
        // Health failure: ignored in LOAD, halts from RUN, start recovers.
        do_reset("hl_rst");
        repeat (4) step(1'b0, 12'h555, 1'b1);
        repeat (LC + IC - 4) step(1'b0, 12'h555, 1'b0);
        repeat (3) step(1'b0, 12'h555, 1'b0);
        step(1'b0, 12'h555, 1'b1);
        chk("halt_alarm", 32'(alarm), 32'd1);
        chk("halt_ce",    32'(ce),    32'd0);
        repeat (5) step(1'b0, 12'h555, 1'b1);
        step(1'b1, 12'h555, 1'b0);
        chk("halt_exit_alarm", 32'(alarm),   32'd0);
        chk("halt_exit_load",  32'(load_en), 32'd1);
`endif

        // Randomized run against the model.
        do_reset("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            logic s;
            logic hf;
            s  = ($urandom_range(0, 99) < 2);
            hf = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) do_reset("rnd_async");
            step(s, TW'($urandom), hf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
